// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: access-size encodings,
// controller states, fault causes and access legality checks.
package mem_pkg;

  localparam logic [2:0] RwB  = 3'b000;
  localparam logic [2:0] RwH  = 3'b001;
  localparam logic [2:0] RwW  = 3'b010;
  localparam logic [2:0] RwBu = 3'b100;
  localparam logic [2:0] RwHu = 3'b101;

  typedef enum logic [1:0] {StIdle, StReq, StResp, StErr} state_e;

  localparam logic [1:0] CauseNone       = 2'b00;
  localparam logic [1:0] CauseMisaligned = 2'b01;
  localparam logic [1:0] CauseIllegal    = 2'b10;
  localparam logic [1:0] CauseTimeout    = 2'b11;

  function automatic logic access_illegal(input logic rd, input logic wr,
                                          input logic [2:0] rw_type);
    logic bad;
    if (rd && wr)  bad = 1'b1;
    else if (rd)   bad = (rw_type == 3'b011) || (rw_type[2:1] == 2'b11);
    else           bad = rw_type[2] || (rw_type[1:0] == 2'b11);
    return bad;
  endfunction

  function automatic logic access_misaligned(input logic [2:0] rw_type,
                                             input logic [1:0] addr_lo);
    logic bad;
    case (rw_type[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a core access and a 32-bit word-aligned memory port:
// byte enables, replicated store data and extended load data.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  RW_type,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = mem_rdata[{addr, 3'b000} +: 8];
    half_sel   = mem_rdata[{addr[1], 4'b0000} +: 16];
    be         = 4'b1111;
    store_data = wdata;
    case (RW_type[1:0])
      2'b00: begin
        be         = 4'b0001 << addr;
        store_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << {addr[1], 1'b0};
        store_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    case (RW_type)
      RwB:     load_data = {{24{byte_sel[7]}}, byte_sel};
      RwBu:    load_data = {24'b0, byte_sel};
      RwH:     load_data = {{16{half_sel[15]}}, half_sel};
      RwHu:    load_data = {16'b0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store controller: stalls the core while an access is outstanding,
// issues a registered handshaked request and reports faults with a one-cycle pulse.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  RW_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] tmo_cnt_q;
  logic [2:0] rw_type_q;
  logic [1:0] addr_lo_q;
  logic       is_store_q;

  logic       access;
  logic [2:0] la_rw_type;
  logic [1:0] la_addr;
  logic [3:0] la_be;
  logic [31:0] la_store_data;
  logic [31:0] la_load_data;

  assign access = MemRead | MemWrite;
  assign stall  = !rst && (((state_q == StIdle) && access) || (state_q == StReq));

  // Live inputs steer lanes while issuing; captured fields while extending the response.
  assign la_rw_type = (state_q == StIdle) ? RW_type    : rw_type_q;
  assign la_addr    = (state_q == StIdle) ? addr[1:0]  : addr_lo_q;

  mem_lane_align u_lane_align (
    .RW_type    (la_rw_type),
    .addr       (la_addr),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .be         (la_be),
    .store_data (la_store_data),
    .load_data  (la_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      rw_type_q   <= '0;
      addr_lo_q   <= '0;
      is_store_q  <= 1'b0;
      done        <= 1'b0;
      rdata_out   <= '0;
      fault       <= 1'b0;
      fault_cause <= CauseNone;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (access) begin
            rw_type_q  <= RW_type;
            addr_lo_q  <= addr[1:0];
            is_store_q <= MemWrite;
            if (access_illegal(MemRead, MemWrite, RW_type)) begin
              state_q     <= StErr;
              fault       <= 1'b1;
              fault_cause <= CauseIllegal;
            end else if (access_misaligned(RW_type, addr[1:0])) begin
              state_q     <= StErr;
              fault       <= 1'b1;
              fault_cause <= CauseMisaligned;
            end else begin
              state_q   <= StReq;
              tmo_cnt_q <= '0;
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= MemWrite ? la_store_data : 32'h0;
              mem_be    <= la_be;
            end
          end
        end
        StReq: begin
          if (mem_ack || (tmo_cnt_q == TmoLast)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
          end
          if (mem_ack) begin
            state_q   <= StResp;
            done      <= 1'b1;
            rdata_out <= is_store_q ? 32'h0 : la_load_data;
          end else if (tmo_cnt_q == TmoLast) begin
            state_q     <= StErr;
            fault       <= 1'b1;
            fault_cause <= CauseTimeout;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          done      <= 1'b0;
          rdata_out <= '0;
        end
        StErr: begin
          state_q     <= StIdle;
          fault       <= 1'b0;
          fault_cause <= CauseNone;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed table, random accesses against a reference
// model, and a reset-during-request sequence.
module tb_mem_access_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  RW_type;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdata_out;
  logic [1:0]  fault_cause;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .RW_type     (RW_type),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .done        (done),
    .rdata_out   (rdata_out),
    .fault       (fault),
    .fault_cause (fault_cause),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] r;
    int          dly;   // ack delay after first mem_req cycle; >= TMO means no ack
    logic [1:0]  cause;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] erd;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: derived from access size in bytes and byte offset.
  function automatic logic [1:0] m_cause(bit rd, bit wr, logic [2:0] t, logic [31:0] a);
    int unsigned sz, lo;
    if (rd && wr) return 2'b10;
    if (rd && !(t inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'b10;
    if (wr && t > 3'd2) return 2'b10;
    sz = 1 << t[1:0];
    lo = a[1:0];
    if (lo % sz != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] t, logic [31:0] a);
    int unsigned sz, lo;
    sz = 1 << t[1:0];
    lo = a[1:0];
    return 4'(((1 << sz) - 1) << lo);
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] t, logic [31:0] w);
    if (t[1:0] == 2'd0) return 32'(w[7:0]) * 32'h0101_0101;
    if (t[1:0] == 2'd1) return 32'(w[15:0]) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(bit wr, logic [2:0] t, logic [31:0] a, logic [31:0] r);
    logic [31:0] v;
    if (wr) return 32'h0;
    v = r >> (8 * int'(a[1:0]));
    case (t)
      3'd0:    return 32'($signed(v[7:0]));
      3'd4:    return 32'(v[7:0]);
      3'd1:    return 32'($signed(v[15:0]));
      3'd5:    return 32'(v[15:0]);
      default: return r;
    endcase
  endfunction

  task automatic run_access(input string nm, input vec_t v);
    MemRead   = v.rd;
    MemWrite  = v.wr;
    RW_type   = v.t;
    addr      = v.a;
    wdata     = v.w;
    mem_rdata = v.r;
    mem_ack   = 1'b0;
    #1;
    chk({nm, "/stall_n"}, 32'(stall), 32'd1);
    step();
    if (v.cause == 2'b01 || v.cause == 2'b10) begin
      chk({nm, "/fault"}, 32'(fault), 32'd1);
      chk({nm, "/cause"}, 32'(fault_cause), 32'(v.cause));
      chk({nm, "/req_err"}, 32'(mem_req), 32'd0);
      chk({nm, "/stall_err"}, 32'(stall), 32'd0);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      step();
      chk({nm, "/fault_clr"}, {30'(fault), fault_cause}, 32'd0);
      chk({nm, "/req_idle"}, 32'(mem_req), 32'd0);
    end else begin
      for (int k = 0; k < TMO; k++) begin
        chk($sformatf("%s/req%0d", nm, k), 32'(mem_req), 32'd1);
        chk($sformatf("%s/addr%0d", nm, k), mem_addr, v.a & 32'hFFFF_FFFC);
        chk($sformatf("%s/we%0d", nm, k), 32'(mem_we), 32'(v.wr));
        chk($sformatf("%s/be%0d", nm, k), 32'(mem_be), 32'(v.be));
        if (v.wr) chk($sformatf("%s/wd%0d", nm, k), mem_wdata, v.wd);
        chk($sformatf("%s/stall%0d", nm, k), 32'(stall), 32'd1);
        chk($sformatf("%s/done%0d", nm, k), 32'(done), 32'd0);
        // Request bus must not follow the live inputs while outstanding.
        addr    = $urandom;
        wdata   = $urandom;
        RW_type = 3'($urandom);
        mem_ack = (k == v.dly);
        step();
        mem_ack = 1'b0;
        if (k == v.dly) break;
      end
      if (v.dly < TMO) begin
        chk({nm, "/done"}, 32'(done), 32'd1);
        chk({nm, "/rdata"}, rdata_out, v.erd);
        chk({nm, "/stall_resp"}, 32'(stall), 32'd0);
        chk({nm, "/req_resp"}, 32'(mem_req), 32'd0);
        chk({nm, "/fault_resp"}, 32'(fault), 32'd0);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        step();
        chk({nm, "/done_clr"}, 32'(done), 32'd0);
        chk({nm, "/rdata_clr"}, rdata_out, 32'd0);
      end else begin
        chk({nm, "/tmo_fault"}, 32'(fault), 32'd1);
        chk({nm, "/tmo_cause"}, 32'(fault_cause), 32'd3);
        chk({nm, "/tmo_req"}, 32'(mem_req), 32'd0);
        chk({nm, "/tmo_stall"}, 32'(stall), 32'd0);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        mem_ack  = 1'b1;  // stray late ack must be dropped
        step();
        chk({nm, "/tmo_clr"}, {29'(done), fault, fault_cause}, 32'd0);
        step();
        mem_ack = 1'b0;
        chk({nm, "/stray"}, {30'(done), mem_req, fault}, 32'd0);
      end
    end
  endtask

  vec_t tbl[16];
  vec_t rv;

  initial begin
    tbl[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,   2'b00, 4'hF, 32'h0,        32'hDEADBEEF};
    tbl[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80112233, 1,   2'b00, 4'h8, 32'h0,        32'hFFFFFF80};
    tbl[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80112233, 0,   2'b00, 4'h8, 32'h0,        32'h00000080};
    tbl[3]  = '{0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h55555555, 1,   2'b00, 4'hC, 32'hABCDABCD, 32'h0};
    tbl[4]  = '{1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0,   2'b01, 4'h0, 32'h0,        32'h0};
    tbl[5]  = '{1, 1, 3'b010, 32'h100, 32'h0,        32'h0,        0,   2'b10, 4'h0, 32'h0,        32'h0};
    tbl[6]  = '{1, 0, 3'b001, 32'h102, 32'h0,        32'h80010000, 2,   2'b00, 4'hC, 32'h0,        32'hFFFF8001};
    tbl[7]  = '{1, 0, 3'b101, 32'h102, 32'h0,        32'h80010000, 0,   2'b00, 4'hC, 32'h0,        32'h00008001};
    tbl[8]  = '{0, 1, 3'b000, 32'h301, 32'h12345678, 32'h0,        1,   2'b00, 4'h2, 32'h78787878, 32'h0};
    tbl[9]  = '{0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0,        3,   2'b00, 4'hF, 32'hCAFEF00D, 32'h0};
    tbl[10] = '{1, 0, 3'b011, 32'h101, 32'h0,        32'h0,        0,   2'b10, 4'h0, 32'h0,        32'h0};
    tbl[11] = '{0, 1, 3'b100, 32'h100, 32'h0,        32'h0,        0,   2'b10, 4'h0, 32'h0,        32'h0};
    tbl[12] = '{1, 0, 3'b010, 32'h600, 32'h0,        32'h0,        255, 2'b11, 4'hF, 32'h0,        32'h0};
    tbl[13] = '{1, 0, 3'b010, 32'h604, 32'h0,        32'h13579BDF, 0,   2'b00, 4'hF, 32'h0,        32'h13579BDF};
    tbl[14] = '{0, 1, 3'b001, 32'h201, 32'h0,        32'h0,        0,   2'b01, 4'h0, 32'h0,        32'h0};
    tbl[15] = '{1, 0, 3'b000, 32'h101, 32'h0,        32'h0000FE00, 0,   2'b00, 4'h2, 32'h0,        32'hFFFFFFFE};

    rst       = 1'b1;
    MemRead   = 1'b1;  // stall must stay low under reset even with an access pending
    MemWrite  = 1'b0;
    RW_type   = 3'b010;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    step();
    step();
    chk("rst/stall", 32'(stall), 32'd0);
    chk("rst/flags", {27'(done), fault, mem_req, mem_we, fault_cause}, 32'd0);
    chk("rst/rdata", rdata_out, 32'd0);
    chk("rst/addr", mem_addr, 32'd0);
    chk("rst/wdata", mem_wdata, 32'd0);
    chk("rst/be", 32'(mem_be), 32'd0);
    MemRead = 1'b0;
    rst     = 1'b0;
    step();
    chk("idle/stall", 32'(stall), 32'd0);

    for (int i = 0; i < 16; i++) run_access($sformatf("tbl%0d", i), tbl[i]);

    // Reset while the request is outstanding.
    MemRead = 1'b1;
    RW_type = 3'b010;
    addr    = 32'h500;
    step();
    chk("rstreq/req", 32'(mem_req), 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("rstreq/stall_rst", 32'(stall), 32'd0);
    step();
    rst     = 1'b0;
    MemRead = 1'b0;
    #1;
    chk("rstreq/req0", 32'(mem_req), 32'd0);
    chk("rstreq/stall0", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rstreq/quiet%0d", i), {29'(done), fault, mem_req, stall}, 32'd0);
    end
    run_access("rstreq/after", tbl[9]);

    for (int i = 0; i < 60; i++) begin
      int unsigned op;
      op    = $urandom_range(0, 9);
      rv.rd = (op < 5) || (op == 9);
      rv.wr = (op >= 5);
      rv.t  = 3'($urandom);
      rv.a  = $urandom;
      rv.w  = $urandom;
      rv.r  = $urandom;
      rv.dly = $urandom_range(0, TMO + 1);
      rv.cause = m_cause(rv.rd, rv.wr, rv.t, rv.a);
      if (rv.cause == 2'b00 && rv.dly >= TMO) rv.cause = 2'b11;
      rv.be  = m_be(rv.t, rv.a);
      rv.wd  = m_wdata(rv.t, rv.w);
      rv.erd = m_rdata(rv.wr, rv.t, rv.a, rv.r);
      run_access($sformatf("rnd%0d", i), rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
